// File: rtl/qrs_peak_detector.sv
// QRS peak detector: per-sample energy of wavelet details D3/D4, a learned then adaptive
// threshold, and a one-cycle pulse per confirmed peak carrying its amplitude and R-R interval.
module qrs_peak_detector #(
    parameter int          LEARN_LEN   = 256,
    parameter int          REFRACT_LEN = 50,
    parameter int          MAX_WIDTH   = 40,
    parameter int          TIMEOUT     = 500,
    parameter logic [16:0] THR_MIN     = 17'd64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               coef_valid,
    input  logic signed [15:0] D3,
    input  logic signed [15:0] D4,
    output logic               qrs_pulse,
    output logic [16:0]        qrs_amp,
    output logic [15:0]        rr_interval,
    output logic [16:0]        threshold,
    output logic               learning
);
    localparam int LW = $clog2(LEARN_LEN);
    localparam int RW = $clog2(REFRACT_LEN + 1);
    localparam int WW = $clog2(MAX_WIDTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        LEARN      = 2'd0,
        SEARCH     = 2'd1,
        PEAK       = 2'd2,
        REFRACTORY = 2'd3
    } state_t;

    state_t         state_r;
    logic [LW-1:0]  learn_cnt_r;
    logic [16:0]    learn_max_r;
    logic [16:0]    spk_r;
    logic [15:0]    since_r;
    logic [TW-1:0]  phase_r;
    logic [RW-1:0]  ref_cnt_r;
    logic [16:0]    peak_amp_r;
    logic [WW-1:0]  peak_w_r;
    logic           have_beat_r;

    logic [16:0]    e_s;
    logic [15:0]    since_inc_s;
    logic           wrap_s;
    logic [16:0]    spk_conf_s;
    logic [16:0]    learn_top_s;
    logic           confirm_s;

    // Magnitude widened to 17 bits so that -32768 maps to 32768 without overflow
    function automatic logic [16:0] mag17(input logic signed [15:0] v);
        logic [16:0] ext;
        ext = {v[15], v};
        return v[15] ? (17'd0 - ext) : ext;
    endfunction

    function automatic logic [16:0] clamp_thr(input logic [16:0] v);
        return (v < THR_MIN) ? THR_MIN : v;
    endfunction

    // phase_r tracks since_cnt modulo TIMEOUT so the periodic halving needs no divider
    always_comb begin
        e_s         = mag17(D3) + mag17(D4);
        since_inc_s = (since_r == 16'hFFFF) ? since_r : (since_r + 16'd1);
        wrap_s      = (phase_r == TW'(TIMEOUT - 1));
        spk_conf_s  = spk_r - (spk_r >> 3'd3) + (peak_amp_r >> 3'd3);
        learn_top_s = (e_s > learn_max_r) ? e_s : learn_max_r;
        confirm_s   = (state_r == PEAK) &&
                      ((e_s < threshold) || (peak_w_r == WW'(MAX_WIDTH)));
    end

    // Detector FSM, counters and registered outputs; state only moves on valid samples
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= LEARN;
            learn_cnt_r <= '0;
            learn_max_r <= 17'd0;
            spk_r       <= 17'd0;
            since_r     <= 16'd0;
            phase_r     <= '0;
            ref_cnt_r   <= '0;
            peak_amp_r  <= 17'd0;
            peak_w_r    <= '0;
            have_beat_r <= 1'b0;
            qrs_pulse   <= 1'b0;
            qrs_amp     <= 17'd0;
            rr_interval <= 16'd0;
            threshold   <= 17'd0;
            learning    <= 1'b1;
        end else begin
            qrs_pulse <= 1'b0;
            if (coef_valid) begin
                since_r <= since_inc_s;
                phase_r <= wrap_s ? '0 : (phase_r + TW'(1));
                case (state_r)
                    LEARN: begin
                        learn_max_r <= learn_top_s;
                        if (learn_cnt_r == LW'(LEARN_LEN - 1)) begin
                            spk_r     <= learn_top_s;
                            threshold <= clamp_thr(learn_top_s >> 1'b1);
                            learning  <= 1'b0;
                            state_r   <= SEARCH;
                        end else begin
                            learn_cnt_r <= learn_cnt_r + LW'(1);
                        end
                    end
                    SEARCH: begin
                        if (e_s >= threshold) begin
                            state_r    <= PEAK;
                            peak_amp_r <= e_s;
                            peak_w_r   <= WW'(1);
                        end
                        if (wrap_s) begin
                            threshold <= clamp_thr(threshold >> 1'b1);
                            spk_r     <= clamp_thr(spk_r >> 1'b1);
                        end
                    end
                    PEAK: begin
                        if (confirm_s) begin
                            qrs_pulse   <= 1'b1;
                            qrs_amp     <= peak_amp_r;
                            rr_interval <= have_beat_r ? since_inc_s : 16'd0;
                            since_r     <= 16'd0;
                            phase_r     <= '0;
                            have_beat_r <= 1'b1;
                            spk_r       <= spk_conf_s;
                            threshold   <= clamp_thr(spk_conf_s >> 1'b1);
                            ref_cnt_r   <= RW'(REFRACT_LEN);
                            state_r     <= REFRACTORY;
                        end else begin
                            if (e_s > peak_amp_r) begin
                                peak_amp_r <= e_s;
                            end
                            peak_w_r <= peak_w_r + WW'(1);
                        end
                    end
                    REFRACTORY: begin
                        ref_cnt_r <= ref_cnt_r - RW'(1);
                        if (ref_cnt_r == RW'(1)) begin
                            state_r <= SEARCH;
                        end
                    end
                    default: begin
                        state_r <= LEARN;
                    end
                endcase
            end
        end
    end
endmodule
